// File: rtl/issue_queue_if.sv
// Bundle of the issue queue's dispatch, wakeup, select and issue signals.
//
// Handshake semantics: a dispatch transfers on a cycle where disp_valid and
// disp_ready are both high at the rising clock edge. disp_ready depends only
// on registered state, so it may be sampled before disp_valid is decided.
// grant, wb_valid and iss_valid are single-cycle qualifiers with no
// back-pressure: the receiver always accepts them.
interface issue_queue_if #(
    parameter int OPCODE_WIDTH = 7,
    parameter int AGE          = 5,
    parameter int TAG          = 6,
    parameter int PAYLOAD      = 64
);
    logic                    flush;
    logic                    disp_valid;
    logic                    disp_ready;
    logic [OPCODE_WIDTH-1:0] disp_op;
    logic [TAG-1:0]          disp_src1_tag;
    logic [TAG-1:0]          disp_src2_tag;
    logic                    disp_src1_rdy;
    logic                    disp_src2_rdy;
    logic [PAYLOAD-1:0]      disp_payload;
    logic                    wb_valid;
    logic [TAG-1:0]          wb_tag;
    logic [OPCODE_WIDTH-1:0] op [16];
    logic [15:0]             req;
    logic [AGE-1:0]          age [16];
    logic                    grant;
    logic [3:0]              grant_addr;
    logic                    iss_valid;
    logic [OPCODE_WIDTH-1:0] iss_op;
    logic [PAYLOAD-1:0]      iss_payload;
    logic [4:0]              count;

    modport master (
        output flush, disp_valid, disp_op, disp_src1_tag, disp_src2_tag,
               disp_src1_rdy, disp_src2_rdy, disp_payload, wb_valid, wb_tag,
               grant, grant_addr,
        input  disp_ready, op, req, age, iss_valid, iss_op, iss_payload, count
    );

    modport slave (
        input  flush, disp_valid, disp_op, disp_src1_tag, disp_src2_tag,
               disp_src1_rdy, disp_src2_rdy, disp_payload, wb_valid, wb_tag,
               grant, grant_addr,
        output disp_ready, op, req, age, iss_valid, iss_op, iss_payload, count
    );
endinterface

// File: rtl/issue_queue.sv
// 16-entry out-of-order issue queue. Entries wait for both source operands,
// expose op/req/age to an external age-based select arbiter, and free the
// granted entry while registering the issued instruction. Ages of valid
// entries are always the unique values 0..count-1 in program order.
module issue_queue #(
    parameter int OPCODE_WIDTH = 7,
    parameter int AGE          = 5,
    parameter int TAG          = 6,
    parameter int PAYLOAD      = 64
) (
    input logic         clk,
    input logic         rst_n,
    issue_queue_if.slave bus
);
    localparam int N = 16;

    logic [N-1:0]            valid_q;
    logic [OPCODE_WIDTH-1:0] op_q      [N];
    logic [TAG-1:0]          s1_tag_q  [N];
    logic [TAG-1:0]          s2_tag_q  [N];
    logic [N-1:0]            s1_rdy_q;
    logic [N-1:0]            s2_rdy_q;
    logic [AGE-1:0]          age_q     [N];
    logic [PAYLOAD-1:0]      payload_q [N];
    logic [4:0]              count_q;
    logic                    iss_valid_q;
    logic [OPCODE_WIDTH-1:0] iss_op_q;
    logic [PAYLOAD-1:0]      iss_payload_q;

    logic [N-1:0]   req_int;
    logic [3:0]     free_idx;
    logic           disp_ready_int;
    logic           disp_fire;
    logic           issue_ok;
    logic [AGE-1:0] grant_age;
    logic [AGE-1:0] new_age;
    logic           byp1;
    logic           byp2;

    // Request vector, free-slot search and per-cycle event decode.
    always_comb begin
        req_int        = valid_q & s1_rdy_q & s2_rdy_q;
        free_idx       = 4'd0;
        // Scan downwards so the lowest invalid index wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = 4'(i);
        end
        // Registered count only, so a same-cycle grant cannot open a slot.
        disp_ready_int = (count_q < 5'd16);
        disp_fire      = bus.disp_valid & disp_ready_int;
        // req already folds in valid, so a grant to an empty or waiting
        // entry is simply not an issue.
        issue_ok       = bus.grant & req_int[bus.grant_addr];
        grant_age      = age_q[bus.grant_addr];
        new_age        = AGE'(count_q) - AGE'(issue_ok);
        byp1 = bus.disp_src1_rdy | (bus.wb_valid & (bus.wb_tag == bus.disp_src1_tag));
        byp2 = bus.disp_src2_rdy | (bus.wb_valid & (bus.wb_tag == bus.disp_src2_tag));
    end

    // Entry storage: issue frees, wakeup sets ready bits, ages compact on
    // issue, and dispatch fills the lowest slot that was empty before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            for (int i = 0; i < N; i++) begin
                op_q[i]      <= '0;
                s1_tag_q[i]  <= '0;
                s2_tag_q[i]  <= '0;
                age_q[i]     <= '0;
                payload_q[i] <= '0;
            end
        end else if (bus.flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (valid_q[i]) begin
                    if (issue_ok && (4'(i) == bus.grant_addr)) begin
                        valid_q[i] <= 1'b0;
                    end else begin
                        if (bus.wb_valid && (s1_tag_q[i] == bus.wb_tag)) s1_rdy_q[i] <= 1'b1;
                        if (bus.wb_valid && (s2_tag_q[i] == bus.wb_tag)) s2_rdy_q[i] <= 1'b1;
                        if (issue_ok && (age_q[i] > grant_age)) age_q[i] <= age_q[i] - 1'b1;
                    end
                end else if (disp_fire && (4'(i) == free_idx)) begin
                    valid_q[i]   <= 1'b1;
                    op_q[i]      <= bus.disp_op;
                    s1_tag_q[i]  <= bus.disp_src1_tag;
                    s2_tag_q[i]  <= bus.disp_src2_tag;
                    s1_rdy_q[i]  <= byp1;
                    s2_rdy_q[i]  <= byp2;
                    age_q[i]     <= new_age;
                    payload_q[i] <= bus.disp_payload;
                end
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (bus.flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 5'(disp_fire) - 5'(issue_ok);
        end
    end

    // Issue register toward register-read; iss_valid pulses once per issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q   <= 1'b0;
            iss_op_q      <= '0;
            iss_payload_q <= '0;
        end else if (bus.flush) begin
            iss_valid_q <= 1'b0;
        end else begin
            iss_valid_q <= issue_ok;
            if (issue_ok) begin
                iss_op_q      <= op_q[bus.grant_addr];
                iss_payload_q <= payload_q[bus.grant_addr];
            end
        end
    end

    // Per-entry arbiter view; empty entries report age 0 and no request.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.op[i]  = op_q[i];
            bus.age[i] = valid_q[i] ? age_q[i] : '0;
        end
        bus.req = req_int;
    end

    assign bus.disp_ready  = disp_ready_int;
    assign bus.iss_valid   = iss_valid_q;
    assign bus.iss_op      = iss_op_q;
    assign bus.iss_payload = iss_payload_q;
    assign bus.count       = count_q;
endmodule

// File: doc/issue_queue.md
# issue_queue

16-entry out-of-order issue queue that holds dispatched instructions until their source operands are ready and presents per-entry `op`/`req`/`age` vectors to the age-based select arbiter. It accepts one instruction per cycle from dispatch and tracks operand readiness via a result-tag wakeup bus. It also takes one grant per cycle back from the arbiter, which selects the oldest ready entry. It frees the granted entry and registers the issued instruction toward the register-read stage.

## Interface
- `OPCODE_WIDTH`, 7, opcode field width
- `AGE`, 5, age field width; must hold 0..15
- `TAG`, 6, physical register tag width
- `PAYLOAD`, 64, opaque per-instruction payload width (dest tag, imm, funct, etc.)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  **asynchronous, active-low reset**
- `flush`  in  1  synchronous pipeline flush
- `disp_valid`  in  1  dispatch request
- `disp_ready`  out  1  queue can accept this cycle
- `disp_op`  in  OPCODE_WIDTH  opcode
- `disp_src1_tag`, `disp_src2_tag`  in  TAG each  source tags
- `disp_src1_rdy`, `disp_src2_rdy`  in  1 each  source already available at dispatch
- `disp_payload`  in  PAYLOAD  payload
- `wb_valid`  in  1  wakeup broadcast valid
- `wb_tag`  in  TAG  tag of result becoming available
- `op`  out  16 x OPCODE_WIDTH  per-entry opcode to arbiter (unpacked array)
- `req`  out  16 x 1  per-entry request: valid & src1 ready & src2 ready
- `age`  out  16 x AGE  per-entry age; 0 = oldest
- `grant`  in  1  arbiter grant valid this cycle
- `grant_addr`  in  4  entry index selected by arbiter
- `iss_valid`  out  1  registered issued instruction valid
- `iss_op`  out  OPCODE_WIDTH  issued opcode
- `iss_payload`  out  PAYLOAD  issued payload
- `count`  out  5  number of valid entries

## Operation
- Entry state: `valid`, `op`, `src1_tag`/`src1_rdy`, `src2_tag`/`src2_rdy`, `age`, `payload`.
- `req[i]`, `op[i]` and `age[i]` are combinational from entry registers. Invalid entries drive `req=0`, `age=0`, and `op` equal to the stored value.
- **Age scheme:** valid entries always hold unique ages 0..count-1 in program order.
  - **Issue:** on a valid issue of entry g, every valid entry with `age > age[g]` decrements by 1.
- **Dispatch:**
  - `disp_ready = (count < 16)`, computed from registered `count` only. It is not combinationally dependent on grant.
  - On `disp_valid & disp_ready`, the lowest-index entry invalid before the edge is written.
  - Its age = `count` − (1 if a valid issue occurs the same cycle, else 0).
  - A just-freed entry is not reused in the same cycle.
- **Wakeup:**
  - On `wb_valid`, every valid entry whose `srcN_tag == wb_tag` sets `srcN_rdy`.
  - A dispatching instruction whose src tag matches the same-cycle `wb_tag` is written with that rdy bit set (bypass).
- **Issue:**
  - A valid issue is `grant & valid[grant_addr] & req[grant_addr]`.
  - The entry is cleared at the edge, `count` decrements, and `iss_op`/`iss_payload` are captured with `iss_valid=1`.
  - A grant to an invalid or non-ready entry is ignored: no state change, `iss_valid=0` next cycle.
- **Count:**
  - `count` next = `count` + dispatch − valid issue.
  - Dispatch and issue in the same cycle leave `count` unchanged.
- **Flush:** highest priority.
  - All `valid` clear, `count=0`, `iss_valid=0` next cycle.
  - Same-cycle dispatch, wakeup and grant are discarded.

## Timing
- **Reset (async assert, `rst_n=0`):**
  - all `valid=0`, `count=0`, `disp_ready=1`
  - `iss_valid=0`, `iss_op=0`, `iss_payload=0`
  - all `req=0`, `age=0`
- **Dispatch latency:** accepted at edge N → `req` visible in cycle N+1 if both sources are ready.
- **Wakeup latency:** `wb_valid` at edge N → `req` high in cycle N+1.
- **Select loop:** `req`/`age` in cycle N → arbiter → `grant`/`grant_addr` in cycle N → entry freed at edge N+1, `iss_valid` high during cycle N+1.
  - Sustains one issue per cycle.
  - The granted entry's `req` drops in cycle N+1, so it is never double-issued.
- **`iss_valid`:** a single-cycle pulse per issue with no back-pressure; downstream always accepts.
- **Full:** at `count==16`, `disp_ready=0` even if a grant frees an entry that cycle. Dispatch resumes in the following cycle.

## Test plan
1. **Reset/idle:** assert `rst_n=0` mid-traffic with 5 entries valid → all outputs at reset values immediately; `disp_ready=1`, `count=0` after release.
2. **Ordering:** dispatch A, B, C with all sources ready, grant always to the `age==0` entry → `iss_op` order A, B, C on consecutive cycles; ages go A=0, B=1, C=2 → B=0, C=1 → C=0.
3. **Wakeup:**
   - Dispatch X with `src1_rdy=0`, `src1_tag=0x12` → `req=0`.
   - `wb_valid`, `wb_tag=0x12` → `req=1` next cycle.
   - Dispatch with tag matching a same-cycle wakeup → `req=1` the cycle after dispatch.
4. **Full:** dispatch 16 entries → `count=16`, `disp_ready=0`. Grant one → `count=15`, `disp_ready=1` next cycle; the new entry gets `age=15` and occupies the freed index.
5. **Simultaneous events:** with 4 entries valid, grant the `age=1` entry and dispatch in the same cycle → ages 0, 1, 2 remain unique and the new entry has age 3, `count=4`. A grant to an invalid index leaves `count` unchanged and gives `iss_valid=0`.
6. **Flush:** flush with 7 entries valid plus a concurrent dispatch and grant → `count=0`, all `req=0`, `iss_valid=0` next cycle.
